// File: rtl/bcd_2_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one bit per cycle.
// Valid/ready handshake on both sides; saturates on overflow and flags non-decimal digits.
module bcd_2_bin #(
  parameter int BIN_WIDTH = 8,
  parameter int BCD_WIDTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [BCD_WIDTH-1:0][3:0]  bcd_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [BIN_WIDTH-1:0]       bin_o,
  output logic                       err_digit_o,
  output logic                       ovf_o
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int SH_W  = BCD_WIDTH * 4 + BIN_WIDTH;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [BCD_WIDTH-1:0][3:0]   bcd_q, bcd_d;
  logic [BCD_WIDTH-1:0][3:0]   bcd_shift, bcd_fix;
  logic [BIN_WIDTH-1:0]        bin_q, bin_d, bin_shift;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        ovf_q, ovf_d;
  logic [BCD_WIDTH-1:0]        digit_bad;
  logic                        any_bad;
  logic [SH_W-1:0]             shifted;

  // One right shift of the joint register: digit 0's LSB falls into the binary MSB.
  assign shifted   = {bcd_q, bin_q} >> 1;
  assign bcd_shift = shifted[SH_W-1:BIN_WIDTH];
  assign bin_shift = shifted[BIN_WIDTH-1:0];

  generate
    for (genvar gi = 0; gi < BCD_WIDTH; gi++) begin : g_digit
      assign digit_bad[gi] = (bcd_i[gi] > 4'd9);
      assign bcd_fix[gi]   = bcd_shift[gi][3] ? (bcd_shift[gi] - 4'd3) : bcd_shift[gi];
    end
  endgenerate

  assign any_bad = |digit_bad;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          bcd_d   = bcd_i;
          bin_d   = '0;
          cnt_d   = '0;
          err_d   = any_bad;
          ovf_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = bcd_fix;
        bin_d = bin_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          // Any decimal weight left after all bits are extracted means the value didn't fit.
          ovf_d   = |bcd_fix;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);

  always_comb begin
    bin_o       = '0;
    err_digit_o = 1'b0;
    ovf_o       = 1'b0;
    if (state_q == DONE) begin
      if (err_q) begin
        err_digit_o = 1'b1;
      end else if (ovf_q) begin
        bin_o = '1;
        ovf_o = 1'b1;
      end else begin
        bin_o = bin_q;
      end
    end
  end

endmodule

// File: tb/tb_bcd_2_bin.sv
// Randomized self-checking bench for bcd_2_bin against a decimal-arithmetic reference.
module tb_bcd_2_bin;

  localparam int BIN_WIDTH = 8;
  localparam int BCD_WIDTH = 3;
  localparam int BCD_W     = BCD_WIDTH * 4;

  logic                      clk = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      valid_i = 1'b0;
  logic                      ready_o;
  logic [BCD_WIDTH-1:0][3:0] bcd_i = '0;
  logic                      valid_o;
  logic                      ready_i = 1'b0;
  logic [BIN_WIDTH-1:0]      bin_o;
  logic                      err_digit_o;
  logic                      ovf_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_2_bin #(.BIN_WIDTH(BIN_WIDTH), .BCD_WIDTH(BCD_WIDTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .bcd_i       (bcd_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .bin_o       (bin_o),
    .err_digit_o (err_digit_o),
    .ovf_o       (ovf_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal value from digits; returns {err, ovf, bin}.
  function automatic logic [BIN_WIDTH+1:0] model(input logic [BCD_W-1:0] d);
    longint unsigned val = 0;
    bit err = 1'b0;
    logic [BIN_WIDTH+1:0] res;
    longint unsigned max_val = (64'd1 << BIN_WIDTH) - 1;
    for (int i = BCD_WIDTH - 1; i >= 0; i--) begin
      int unsigned dg = int'(d[i*4 +: 4]);
      if (dg > 9) err = 1'b1;
      val = val * 10 + dg;
    end
    res = '0;
    if (err) begin
      res[BIN_WIDTH+1] = 1'b1;
    end else if (val > max_val) begin
      res[BIN_WIDTH] = 1'b1;
      res[BIN_WIDTH-1:0] = '1;
    end else begin
      res[BIN_WIDTH-1:0] = BIN_WIDTH'(val);
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [BCD_W-1:0] d, input int bp, input bit poke);
    logic [BIN_WIDTH+1:0] exp;
    logic [BIN_WIDTH-1:0] held_bin;
    logic [1:0]           held_flags;
    int  edges;
    bit  quiet_ok;
    bit  hold_ok;
    exp = model(d);
    edges = 0;
    while (!ready_o && edges < 50) begin
      tick();
      edges++;
    end
    check("ready_before_req", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    bcd_i   = d;
    tick();
    valid_i = 1'b0;
    bcd_i   = BCD_W'($urandom);
    // Edge count includes the accepting edge itself.
    edges    = 1;
    quiet_ok = 1'b1;
    while (!valid_o && edges < 50) begin
      if (bin_o != '0 || err_digit_o || ovf_o || ready_o) quiet_ok = 1'b0;
      tick();
      edges++;
    end
    check("latency", 32'(edges), 32'(BIN_WIDTH + 1));
    check("quiet_in_conv", 32'(quiet_ok), 32'd1);
    check("bin", 32'(bin_o), 32'(exp[BIN_WIDTH-1:0]));
    check("err_digit", 32'(err_digit_o), 32'(exp[BIN_WIDTH+1]));
    check("ovf", 32'(ovf_o), 32'(exp[BIN_WIDTH]));
    if (bp > 0) begin
      held_bin   = bin_o;
      held_flags = {err_digit_o, ovf_o};
      hold_ok    = 1'b1;
      for (int i = 0; i < bp; i++) begin
        valid_i = poke;
        bcd_i   = BCD_W'($urandom);
        tick();
        if (!valid_o || ready_o || bin_o !== held_bin || {err_digit_o, ovf_o} !== held_flags)
          hold_ok = 1'b0;
      end
      valid_i = 1'b0;
      check("hold_under_backpressure", 32'(hold_ok), 32'd1);
    end
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("handoff", 32'({valid_o, ready_o}), 32'b01);
    $display("txn bcd=%03h bp=%0d bin=0x%02h err=%0b ovf=%0b lat=%0d",
             d, bp, exp[BIN_WIDTH-1:0], exp[BIN_WIDTH+1], exp[BIN_WIDTH], edges);
  endtask

  initial begin
    bit saw_valid;
    logic [BCD_W-1:0] d;

    tick();
    tick();
    rst_i = 1'b0;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_bin", 32'(bin_o), 32'd0);
    check("rst_flags", 32'({err_digit_o, ovf_o}), 32'd0);

    run_txn(12'h255, 0, 1'b0);
    run_txn(12'h256, 0, 1'b0);
    run_txn(12'h000, 0, 1'b0);
    run_txn(12'h0A3, 0, 1'b0);
    run_txn(12'h128, 5, 1'b1);
    run_txn(12'h999, 2, 1'b0);
    run_txn(12'hFFF, 1, 1'b1);
    run_txn(12'h001, 0, 1'b0);

    // Reset during conversion discards it.
    valid_i = 1'b1;
    bcd_i   = 12'h099;
    tick();
    valid_i = 1'b0;
    tick();
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midconv_rst_ready", 32'(ready_o), 32'd1);
    check("midconv_rst_valid", 32'(valid_o), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (valid_o) saw_valid = 1'b1;
      tick();
    end
    check("no_result_after_rst", 32'(saw_valid), 32'd0);
    $display("txn reset during conversion of 099");
    run_txn(12'h042, 0, 1'b0);

    // Reset while holding a result in DONE.
    valid_i = 1'b1;
    bcd_i   = 12'h077;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("done_before_rst", 32'(valid_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("done_rst_state", 32'({valid_o, ready_o, bin_o}), 32'({2'b01, 8'h00}));
    $display("txn reset while holding result of 077");

    for (int v = 0; v < 1000; v++) begin
      d = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      run_txn(d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 100; i++) begin
      run_txn(BCD_W'($urandom), int'($urandom_range(0, 2)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
